// File: rtl/core_pkg.sv
// Shared pipeline encodings: writeback-source one-hot codes, hazard FSM states
// and E-stage forward selects used by the hazard controller and datapath.
package core_pkg;

    localparam logic [3:0] WB_ALU  = 4'b0001;
    localparam logic [3:0] WB_MEM  = 4'b0010;
    localparam logic [3:0] WB_PC8  = 4'b0100;
    localparam logic [3:0] WB_HILO = 4'b1000;
    localparam logic [3:0] WB_HI   = WB_HILO;
    localparam logic [3:0] WB_LO   = WB_HILO;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DMISS = 2'd1,
        MULTW = 2'd2,
        IMISS = 2'd3
    } hzState_t;

    // Register 0 is hardwired to zero, so it never produces a dependency.
    function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Count visible one cycle after the event; holds at all-ones, never backpressures.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage hazard unit: zero-latency stall/flush/forward from stage tags, registered
// cause FSM, mult-busy and sticky miss watchdog; HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hitF,
    input  logic             hitM,
    input  logic [1:0]       branchD,
    input  logic             jumpd,
    input  logic             pcsrcd,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic [3:0]       WBSrcE,
    input  logic [3:0]       WBSrcM,
    input  logic             MultStartE,
    input  logic             MultDoneE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] perf_dmiss,
    output logic [CNT_W-1:0] perf_imiss,
    output logic [CNT_W-1:0] perf_mult,
    output logic [CNT_W-1:0] perf_lduse,
    output logic [CNT_W-1:0] perf_brstall,
    output logic [CNT_W-1:0] perf_redirect,
`endif
    output logic             miss_err
);

    localparam int              WD_W    = $clog2(MISS_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MISS_TIMEOUT - 1);

    hzState_t        state;
    hzState_t        nextState;
    logic            multBusy;
    logic            dMiss;
    logic            iMiss;
    logic            multWait;
    logic            fullStall;
    logic            lwStall;
    logic            brStall;
    logic            depStall;
    logic            inMiss;
    logic [WD_W-1:0] wdCnt;

    always_comb begin
        forwardAE = FWD_RF;
        if (RegWriteM && regMatch(RsE, WriteRegM)) begin
            forwardAE = FWD_M;
        end else if (RegWriteW && regMatch(RsE, WriteRegW)) begin
            forwardAE = FWD_W;
        end
        forwardBE = FWD_RF;
        if (RegWriteM && regMatch(RtE, WriteRegM)) begin
            forwardBE = FWD_M;
        end else if (RegWriteW && regMatch(RtE, WriteRegW)) begin
            forwardBE = FWD_W;
        end
    end

    assign forwardAD = RegWriteM && regMatch(RsD, WriteRegM);
    assign forwardBD = RegWriteM && regMatch(RtD, WriteRegM);

    assign lwStall = (WBSrcE == WB_MEM) && (WriteRegE != 5'd0)
                   && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign brStall = (branchD != 2'b00)
                   && ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD)))
                    || ((WBSrcM == WB_MEM) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    assign depStall = lwStall || brStall;

    assign dMiss = !hitM;
    assign iMiss = !hitF;
    // The done pulse releases the pipe in its own cycle, before multBusy clears.
    assign multWait  = multBusy && ((WBSrcE == WB_HI) || (WBSrcE == WB_LO)) && !MultDoneE;
    assign fullStall = dMiss || multWait;

    assign stallF = fullStall || iMiss || depStall;
    assign stallD = fullStall || depStall;
    assign stallE = fullStall;
    assign stallM = fullStall;
    assign stallW = fullStall;
    assign flushE = depStall && !fullStall;

    always_comb begin
        nextState = state;
        unique case (state)
            RUN: begin
                if (dMiss) begin
                    nextState = DMISS;
                end else if (multWait) begin
                    nextState = MULTW;
                end else if (iMiss) begin
                    nextState = IMISS;
                end
            end
            DMISS:   if (hitM) nextState = RUN;
            MULTW:   if (MultDoneE) nextState = RUN;
            IMISS: begin
                if (dMiss) begin
                    nextState = DMISS;
                end else if (hitF) begin
                    nextState = RUN;
                end
            end
            default: nextState = RUN;
        endcase
    end

    // Counts consecutive cycles spent in a miss state, including the entry cycle.
    assign inMiss = (nextState == DMISS) || (nextState == IMISS);

    hazard_perf_cnt #(.W(WD_W)) uWatchdog (
        .clk (clk),
        .rst (rst),
        .clr (!inMiss),
        .inc (inMiss),
        .cnt (wdCnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            multBusy <= 1'b0;
            miss_err <= 1'b0;
        end else begin
            state <= nextState;
            if (MultStartE) begin
                multBusy <= 1'b1;
            end else if (MultDoneE) begin
                multBusy <= 1'b0;
            end
            if (inMiss && (wdCnt >= WD_LAST)) begin
                miss_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.W(CNT_W)) uPerfDmiss (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (state == DMISS), .cnt (perf_dmiss)
    );
    hazard_perf_cnt #(.W(CNT_W)) uPerfImiss (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (state == IMISS), .cnt (perf_imiss)
    );
    hazard_perf_cnt #(.W(CNT_W)) uPerfMult (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (state == MULTW), .cnt (perf_mult)
    );
    hazard_perf_cnt #(.W(CNT_W)) uPerfLduse (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (lwStall), .cnt (perf_lduse)
    );
    hazard_perf_cnt #(.W(CNT_W)) uPerfBrstall (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (brStall), .cnt (perf_brstall)
    );
    hazard_perf_cnt #(.W(CNT_W)) uPerfRedirect (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (jumpd || pcsrcd), .cnt (perf_redirect)
    );
`else
    logic             unusedRedirect;
    logic [CNT_W-1:0] unusedCntW;
    assign unusedRedirect = jumpd ^ pcsrcd;
    assign unusedCntW     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MISS_TIMEOUT=4; expected values hand-computed.
module tb_hazard_ctrl;
    import core_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       hitF, hitM, jumpd, pcsrcd;
    logic [1:0] branchD;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MultStartE, MultDoneE;
    logic [3:0] WBSrcE, WBSrcM;
    logic       stallF, stallD, stallE, stallM, stallW, flushE;
    logic       forwardAD, forwardBD, miss_err;
    logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_dmiss, perf_imiss, perf_mult, perf_lduse, perf_brstall, perf_redirect;
`endif

    int vecs = 0;
    int errs = 0;

    wire [5:0] stv = {stallF, stallD, stallE, stallM, stallW, flushE};
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_FULL = 6'b111110;
    localparam logic [5:0] S_DEP  = 6'b110001;
    localparam logic [5:0] S_IF   = 6'b100000;

    always #5 clk = ~clk;

    hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hitF(hitF), .hitM(hitM), .branchD(branchD),
        .jumpd(jumpd), .pcsrcd(pcsrcd), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .WBSrcE(WBSrcE), .WBSrcM(WBSrcM), .MultStartE(MultStartE), .MultDoneE(MultDoneE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
`ifdef HAZARD_PERF_EN
        .perf_dmiss(perf_dmiss), .perf_imiss(perf_imiss), .perf_mult(perf_mult),
        .perf_lduse(perf_lduse), .perf_brstall(perf_brstall), .perf_redirect(perf_redirect),
`endif
        .miss_err(miss_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hitF = 1'b1; hitM = 1'b1; branchD = 2'b00; jumpd = 1'b0; pcsrcd = 1'b0;
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        WBSrcE = WB_ALU; WBSrcM = WB_ALU; MultStartE = 1'b0; MultDoneE = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout vecs=%0d", vecs);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b0;
        idle();
        #2;
        chk("rst_stalls", 32'(stv), 32'(S_NONE));
        chk("rst_fwd", 32'({forwardAE, forwardBE, forwardAD, forwardBD}), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(RUN));
        chk("rst_err", 32'(miss_err), 32'd0);
        cyc();
        rst = 1'b1;

        // Forwarding: M beats W, W alone, register 0 never forwards
        RegWriteM = 1'b1; WriteRegM = 5'd5; RsE = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
        #1 chk("fwdAE_M", 32'(forwardAE), 32'(2'b10));
        chk("fwdBE_rf", 32'(forwardBE), 32'(2'b00));
        RegWriteM = 1'b0;
        #1 chk("fwdAE_W", 32'(forwardAE), 32'(2'b01));
        RsE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd0; WriteRegW = 5'd0;
        #1 chk("fwdAE_r0", 32'(forwardAE), 32'(2'b00));
        RtE = 5'd7; RegWriteM = 1'b0; WriteRegW = 5'd7;
        #1 chk("fwdBE_W", 32'(forwardBE), 32'(2'b01));
        idle();
        RsD = 5'd9; RtD = 5'd9; RegWriteM = 1'b1; WriteRegM = 5'd9;
        #1 chk("fwdD_both", 32'({forwardAD, forwardBD}), 32'(2'b11));
        RegWriteM = 1'b0;
        #1 chk("fwdD_off", 32'({forwardAD, forwardBD}), 32'(2'b00));

        // Load-use stall for one cycle
        idle(); WBSrcE = WB_MEM; WriteRegE = 5'd8; RtD = 5'd8;
        #1 chk("lwstall", 32'(stv), 32'(S_DEP));
        cyc(); idle();
        #1 chk("lwstall_next", 32'(stv), 32'(S_NONE));
        WBSrcE = WB_MEM; WriteRegE = 5'd0; RsD = 5'd0;
        #1 chk("lwstall_r0", 32'(stv), 32'(S_NONE));

        // Branch stalls
        idle(); branchD = 2'b01; RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3;
        #1 chk("brstall_E", 32'(stv), 32'(S_DEP));
        branchD = 2'b00;
        #1 chk("brstall_nobr", 32'(stv), 32'(S_NONE));
        idle(); branchD = 2'b10; WBSrcM = WB_MEM; WriteRegM = 5'd4; RtD = 5'd4;
        #1 chk("brstall_Mload", 32'(stv), 32'(S_DEP));
        cyc(); idle();

        // Data miss held 4 cycles, I-miss joins from the 2nd cycle
        hitM = 1'b0;
        #1 chk("dmiss_stall0", 32'(stv), 32'(S_FULL));
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("dmiss_state%0d", k), 32'(dut.state), 32'(DMISS));
            if (k == 2) hitF = 1'b0;
            #1 chk($sformatf("dmiss_stall%0d", k), 32'(stv), 32'(S_FULL));
        end
        chk("dmiss_err_timeout", 32'(miss_err), 32'd1);
        hitM = 1'b1;
        #1 chk("dmiss_exit_stall", 32'(stv), 32'(S_IF));
        cyc();
        chk("dmiss_exit_state", 32'(dut.state), 32'(RUN));
        cyc();
        chk("imiss_state", 32'(dut.state), 32'(IMISS));
        hitM = 1'b0;
        cyc();
        chk("imiss_preempt", 32'(dut.state), 32'(DMISS));
        hitM = 1'b1; hitF = 1'b1;
        cyc();
        chk("preempt_exit", 32'(dut.state), 32'(RUN));
        chk("err_sticky", 32'(miss_err), 32'd1);
        rst = 1'b0;
        #1 chk("err_rst", 32'(miss_err), 32'd0);
        rst = 1'b1;

        // Multiplier wait
        idle(); MultStartE = 1'b1;
        #1 chk("mult_start", 32'(stv), 32'(S_NONE));
        cyc(); MultStartE = 1'b0; WBSrcE = WB_HILO;
        #1 chk("mult_wait0", 32'(stv), 32'(S_FULL));
        cyc();
        chk("mult_state", 32'(dut.state), 32'(MULTW));
        chk("mult_wait1", 32'(stv), 32'(S_FULL));
        cyc();
        chk("mult_wait2", 32'(stv), 32'(S_FULL));
        MultDoneE = 1'b1;
        #1 chk("mult_done", 32'(stv), 32'(S_NONE));
        cyc(); MultDoneE = 1'b0;
        #1 chk("mult_exit_state", 32'(dut.state), 32'(RUN));
        chk("mult_after", 32'(stv), 32'(S_NONE));
        MultStartE = 1'b1; MultDoneE = 1'b1; WBSrcE = WB_ALU;
        cyc(); MultStartE = 1'b0; MultDoneE = 1'b0; WBSrcE = WB_HILO;
        #1 chk("mult_startdone", 32'(stv), 32'(S_FULL));
        MultDoneE = 1'b1;
        cyc(); idle();

        // I-miss combined with load-use
        hitF = 1'b0; WBSrcE = WB_MEM; WriteRegE = 5'd8; RsD = 5'd8;
        #1 chk("imiss_lwstall", 32'(stv), 32'(S_DEP));
        idle();
        cyc();

        // Watchdog on a 6-cycle I-miss, then reset mid-miss
        chk("wd_pre_state", 32'(dut.state), 32'(RUN));
        hitF = 1'b0;
        #1 chk("wd_imiss_stall", 32'(stv), 32'(S_IF));
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("wd_err%0d", k), 32'(miss_err), (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("wd_state%0d", k), 32'(dut.state), 32'(IMISS));
        end
        rst = 1'b0;
        #1 chk("wd_rst_err", 32'(miss_err), 32'd0);
        chk("wd_rst_state", 32'(dut.state), 32'(RUN));
        chk("wd_rst_stall", 32'(stv), 32'(S_IF));
        rst = 1'b1; hitF = 1'b1;
        cyc();
        chk("final_stall", 32'(stv), 32'(S_NONE));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the datapath and consumes that datapath's stage-tag outputs: register numbers, write enables, writeback source, branch/jump status, cache hits and multiplier start/done. From these it produces every per-stage stall, flush and forwarding select the datapath takes as inputs. It combines combinational dependency detection with a registered stall-cause FSM, multiplier-busy tracking and a miss watchdog.

## Interface
- MISS_TIMEOUT, 64: cycles a cache miss may persist before `miss_err` sets.
- CNT_W, 32: width of the performance counters (used only with the macro).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- hitF, hitM  in  1  I-cache and D-cache hit.
- branchD  in  2  nonzero means a branch is in D.
- jumpd, pcsrcd  in  1  jump or taken branch resolved in D.
- RsD, RtD, RsE, RtE  in  5  source registers.
- RegWriteE, RegWriteM, RegWriteW  in  1  stage write enables.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers.
- WBSrcE, WBSrcM  in  4  writeback source, one-hot (package encoding).
- MultStartE, MultDoneE  in  1  multiplier start pulse and done pulse.
- stallF, stallD, stallE, stallM, stallW  out  1  stage holds.
- flushE  out  1  bubble into E.
- forwardAD, forwardBD  out  1  D-stage compare forward from M.
- forwardAE, forwardBE  out  2  E operand select: 00 regfile, 01 resultW, 10 ALUMultOutM.
- miss_err  out  1  sticky miss-timeout flag.

## Operation
- Forwarding is combinational.
  - forwardAE=10 if RsE!=0, RegWriteM and WriteRegM==RsE. Otherwise 01 if RegWriteW and WriteRegW==RsE. Otherwise 00. forwardBE is the same with RtE.
  - forwardAD=1 if RsD!=0, RegWriteM and WriteRegM==RsD. forwardBD is the same with RtD.
- lwstall: WBSrcE==WB_MEM and WriteRegE!=0 and (RtE==RsD or RtE==RsD... i.e. WriteRegE equals RsD or RtD).
- brstall: branchD!=0 and one of the following.
  - RegWriteE and WriteRegE equals RsD or RtD.
  - WBSrcM==WB_MEM and WriteRegM equals RsD or RtD.
- FSM states: RUN, DMISS, MULTW, IMISS.
  - Priority on entry, evaluated every cycle in RUN: !hitM → DMISS; mult_busy and WBSrcE∈{WB_HI,WB_LO} → MULTW; !hitF → IMISS.
  - DMISS exits to RUN on hitM. MULTW exits on MultDoneE. IMISS exits on hitF. A D-miss occurring while in IMISS preempts the state to DMISS.
- Stall outputs are driven by the condition, combinationally in the same cycle it is seen. The state register only tracks cause and duration.
  - Data miss or multiplier wait: stallF, stallD, stallE, stallM and stallW all 1; flushE=0.
  - Instruction miss: stallF=1 only; flushE=0; D, E, M and W keep flowing.
  - lwstall or brstall, with no miss and no multiplier wait: stallF=stallD=1, flushE=1.
  - Otherwise all stall and flush outputs are 0.
- mult_busy is set on MultStartE and cleared on MultDoneE. If both pulse in the same cycle, the result is set. mult_busy holds across stalls.
- Miss watchdog: a counter increments each cycle in DMISS or IMISS and clears on return to RUN. Reaching MISS_TIMEOUT sets miss_err, which stays set until reset.
- jumpd and pcsrcd do not generate stalls. They are used only by the counters.

## Timing
- Reset (rst low, asynchronous): state=RUN, mult_busy=0, watchdog=0, miss_err=0, all counters 0.
  - The combinational outputs still follow their inputs during reset.
  - With all-hit inputs and no dependencies, every stall, flush and forward output is 0.
- Latency is zero cycles from input to stall, flush and forward outputs. State, mult_busy and miss_err update on posedge clk.
- An IMISS and a lwstall can be active together. The result is stallF=stallD=1 and flushE=1.

## Configuration
- HAZARD_PERF_EN defined adds the following CNT_W saturating counters, each exported as an output port:
  - perf_dmiss, perf_imiss and perf_mult: cycles spent in each state.
  - perf_lduse: lwstall cycles.
  - perf_brstall: brstall cycles.
  - perf_redirect: cycles with jumpd or pcsrcd set.
- HAZARD_PERF_EN undefined: no counters and no perf ports exist.

## Structure
- Shared package (core_pkg) holds:
  - The WBSrc one-hot constants: WB_ALU=4'b0001, WB_MEM=4'b0010, WB_PC8=4'b0100, WB_HILO=4'b1000. WB_HI and WB_LO both alias WB_HILO.
  - The FSM state enum.
  - The forward-select constants FWD_RF, FWD_W, FWD_M.
- One sub-module, hazard_perf_cnt: a single saturating counter, instantiated per counter under the macro.

## Test plan
- RegWriteM=1, WriteRegM=5, RsE=5 → forwardAE=10. Then RegWriteM=0, RegWriteW=1, WriteRegW=5 → forwardAE=01. RsE=0 with matching writers → forwardAE=00.
- WBSrcE=WB_MEM, WriteRegE=8, RtD=8 → stallF=stallD=flushE=1 for one cycle; all outputs 0 the next cycle.
- branchD=01, RegWriteE=1, WriteRegE=RsD=3 → brstall. WBSrcM=WB_MEM with WriteRegM=RtD → brstall.
- hitM held 0 for 4 cycles → all five stalls 1 for those cycles, state DMISS. hitF=0 asserted concurrently → state stays DMISS. Return to RUN on hitM.
- MultStartE pulse, then WBSrcE=WB_HILO → full stall until MultDoneE; stalls drop in the MultDoneE cycle.
- MISS_TIMEOUT=4 with hitF=0 for 6 cycles → miss_err=1 from the 4th cycle and held. rst pulse low mid-miss → miss_err=0 and state RUN immediately.
